// File: rtl/pll_clken_gen.sv
// PLL lock qualifier with NUM_CH programmable divide-by-D clock-enable strobes.
// Define PLL_CLKEN_PHASE_EN to add the ~50% duty ph_out level outputs.
module pll_clken_gen #(
  parameter int NUM_CH          = 2,
  parameter int DIV_W           = 8,
  parameter int DIV_INIT        = 14,
  parameter int LOCK_STABLE_CYC = 1024,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pll_lock,
  input  logic              div_we,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_wdata,
  output logic [NUM_CH-1:0] ce_out,
`ifdef PLL_CLKEN_PHASE_EN
  output logic [NUM_CH-1:0] ph_out,
`endif
  output logic              rst_out,
  output logic              ready
);

  localparam int LW = $clog2(LOCK_STABLE_CYC);
  localparam logic [LW-1:0] LAST = LW'(LOCK_STABLE_CYC - 1);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] INIT = DIV_W'(DIV_INIT);

  typedef enum logic [1:0] {HOLD, WAIT, RUN} state_t;

  state_t          state;
  logic            sync1;
  logic            lock_s;
  logic [LW-1:0]   stab_cnt;
  logic            run;

  logic [DIV_W-1:0] act_q [NUM_CH];
  logic [DIV_W-1:0] shd_q [NUM_CH];
  logic [DIV_W-1:0] cnt_q [NUM_CH];
  logic [NUM_CH-1:0] pend_q;

  logic [DIV_W-1:0] act_d [NUM_CH];
  logic [DIV_W-1:0] shd_d [NUM_CH];
  logic [DIV_W-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0] pend_d;
  logic [NUM_CH-1:0] ce_d;
`ifdef PLL_CLKEN_PHASE_EN
  logic [NUM_CH-1:0] ph_d;
`endif

  assign run = (state == RUN);

  always_comb begin
    logic             hit;
    logic             wrap;
    logic [DIV_W-1:0] d;
    logic [DIV_W-1:0] c;
`ifdef PLL_CLKEN_PHASE_EN
    logic [DIV_W:0]   half;
    half = '0;
    ph_d = '0;
`endif
    hit    = 1'b0;
    wrap   = 1'b0;
    d      = '0;
    c      = '0;
    pend_d = '0;
    ce_d   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      hit       = div_we && (int'(div_sel) == k);
      shd_d[k]  = hit ? div_wdata : shd_q[k];
      pend_d[k] = pend_q[k] | hit;
      d         = act_q[k];
      c         = cnt_q[k];
      // Idle or disabled channels take a new divisor at once and
      // count this edge as phase 0 of the new period.
      if ((!run || act_q[k] == '0) && pend_d[k]) begin
        d         = shd_d[k];
        c         = '0;
        pend_d[k] = 1'b0;
      end
      wrap    = run && (d != '0) && (c == d - ONE);
      ce_d[k] = wrap;
      if (!run || d == '0 || wrap)
        cnt_d[k] = '0;
      else
        cnt_d[k] = c + ONE;
      act_d[k] = d;
      if (wrap && pend_d[k]) begin
        act_d[k]  = shd_d[k];
        pend_d[k] = 1'b0;
      end
`ifdef PLL_CLKEN_PHASE_EN
      half    = ({1'b0, act_d[k]} + {1'b0, ONE}) >> 1;
      ph_d[k] = run && (act_d[k] != '0) &&
                ({1'b0, cnt_d[k]} < half);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      lock_s   <= 1'b0;
      state    <= HOLD;
      stab_cnt <= '0;
      ready    <= 1'b0;
      rst_out  <= 1'b1;
      ce_out   <= '0;
      pend_q   <= '0;
`ifdef PLL_CLKEN_PHASE_EN
      ph_out   <= '0;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
        act_q[k] <= INIT;
        shd_q[k] <= INIT;
        cnt_q[k] <= '0;
      end
    end else begin
      sync1   <= pll_lock;
      lock_s  <= sync1;
      ready   <= run;
      rst_out <= !run;
      ce_out  <= ce_d;
      pend_q  <= pend_d;
`ifdef PLL_CLKEN_PHASE_EN
      ph_out  <= ph_d;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
        act_q[k] <= act_d[k];
        shd_q[k] <= shd_d[k];
        cnt_q[k] <= cnt_d[k];
      end
      unique case (state)
        HOLD: begin
          state    <= WAIT;
          stab_cnt <= '0;
        end
        WAIT: begin
          if (!lock_s) begin
            stab_cnt <= '0;
          end else if (stab_cnt == LAST) begin
            state    <= RUN;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= stab_cnt + LW'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state    <= WAIT;
            stab_cnt <= '0;
          end
        end
        default: begin
          state    <= HOLD;
          stab_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_clken_gen.sv
// Directed bench for pll_clken_gen: lock qualification, strobe timing,
// divisor updates, lock loss and mid-run reset.
module tb_pll_clken_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       div_we;
  logic [0:0] div_sel;
  logic [7:0] div_wdata;
  logic [1:0] ce_out;
`ifdef PLL_CLKEN_PHASE_EN
  logic [1:0] ph_out;
`endif
  logic       rst_out;
  logic       ready;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pll_clken_gen #(
    .NUM_CH(2),
    .DIV_W(8),
    .DIV_INIT(14),
    .LOCK_STABLE_CYC(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_lock(pll_lock),
    .div_we(div_we),
    .div_sel(div_sel),
    .div_wdata(div_wdata),
    .ce_out(ce_out),
`ifdef PLL_CLKEN_PHASE_EN
    .ph_out(ph_out),
`endif
    .rst_out(rst_out),
    .ready(ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic wr(input int ch, input int val);
    div_we    = 1'b1;
    div_sel   = 1'(ch);
    div_wdata = 8'(val);
  endtask

  // Reset released in cycle 1: ready low through cycle 19, high in cycle 20.
  task automatic lock_seq(input string tag);
    for (int i = 1; i <= 18; i++) begin
      next();
      chk({tag, "_wait"}, {29'b0, ready, rst_out, |ce_out}, 32'b010);
    end
    next();
    chk({tag, "_ready"}, {30'b0, ready, rst_out}, 32'b10);
  endtask

  initial begin
    logic [1:0] e;
    reset     = 1'b1;
    pll_lock  = 1'b1;
    div_we    = 1'b0;
    div_sel   = 1'b0;
    div_wdata = 8'd0;
    repeat (3) @(posedge clk);
    next();
    chk("reset_vals", {28'b0, ce_out, rst_out, ready}, 32'b0010);
    reset = 1'b0;
    lock_seq("lock1");

    // Offsets from T0; ch1 written to 3 at +5, ch0 to 0 at +42 and 5 at +60.
    for (int off = 0; off <= 75; off++) begin
      if (off > 0) next();
      div_we = 1'b0;
      e[0] = (off <= 55) ? (off % 14 == 13)
                         : (off > 60 && (off - 60) % 5 == 0);
      e[1] = (off == 13) || (off > 13 && (off - 13) % 3 == 0);
      chk($sformatf("ce_run1_t%0d", off), {30'b0, ce_out}, {30'b0, e});
      if (off == 5)  wr(1, 3);
      if (off == 42) wr(0, 0);
      if (off == 60) wr(0, 5);
    end

    // One-cycle lock glitch in cycle X.
    next();
    pll_lock = 1'b0;
    next();
    pll_lock = 1'b1;
    next();
    next();
    chk("glitch_x3_ready", {31'b0, ready}, 32'b1);
    for (int i = 4; i <= 19; i++) begin
      next();
      chk($sformatf("glitch_x%0d", i),
          {29'b0, ready, rst_out, |ce_out}, 32'b010);
    end
    next();
    chk("relock_ready", {30'b0, ready, rst_out}, 32'b10);
    for (int off = 0; off <= 10; off++) begin
      if (off > 0) next();
      e[0] = (off % 5 == 4);
      e[1] = (off % 3 == 2);
      chk($sformatf("ce_run2_t%0d", off), {30'b0, ce_out}, {30'b0, e});
    end

    // Pending divisor 7 on ch0, then reset before it can land.
    next();
    wr(0, 7);
    next();
    div_we = 1'b0;
    reset  = 1'b1;
    next();
    chk("midrun_reset", {28'b0, ce_out, rst_out, ready}, 32'b0010);
    reset = 1'b0;
    lock_seq("lock3");
    for (int off = 0; off <= 14; off++) begin
      if (off > 0) next();
      e = (off == 13) ? 2'b11 : 2'b00;
      chk($sformatf("ce_run3_t%0d", off), {30'b0, ce_out}, {30'b0, e});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
